// File: rtl/rs232in_hex.sv
// 8N1 UART receiver with an ASCII hex line parser: bytes are deserialised from
// serial_in, and hex digits terminated by CR/LF are packed into a word.
module rs232in_hex #(
    parameter int frequency   = 50_000_000,
    parameter int bps         = 115_200,
    parameter int word_digits = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     serial_in,
    output logic [7:0]               received_data,
    output logic                     received_valid,
    output logic                     framing_error,
    output logic [4*word_digits-1:0] word,
    output logic                     word_valid,
    output logic                     word_overflow,
    output logic                     parse_error
);
    localparam int DIV   = frequency / bps;
    localparam int WW    = 4 * word_digits;
    localparam int CNT_W = $clog2(DIV);
    localparam int DCW   = $clog2(word_digits + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
    localparam logic [DCW-1:0]   MAX_DIGITS = DCW'(word_digits);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       received_data_q, received_data_d;
    logic             received_valid_q, received_valid_d;
    logic             framing_error_q, framing_error_d;
    logic [WW-1:0]    acc_q, acc_d;
    logic [DCW-1:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WW-1:0]    word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             word_overflow_q, word_overflow_d;
    logic             parse_error_q, parse_error_d;

    // Returns {is_hex, nibble} for an ASCII byte.
    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            r = {1'b1, b[3:0] + 4'd9};
        return r;
    endfunction

    logic [4:0] nib;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bit_idx_d        = bit_idx_q;
        shift_d          = shift_q;
        received_data_d  = received_data_q;
        received_valid_d = 1'b0;
        framing_error_d  = 1'b0;
        acc_d            = acc_q;
        count_d          = count_q;
        ovf_d            = ovf_q;
        word_d           = word_q;
        word_valid_d     = 1'b0;
        word_overflow_d  = 1'b0;
        parse_error_d    = 1'b0;
        nib              = hex_nibble(received_data_q);

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7)
                        state_d = S_STOP;
                    else
                        bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        received_data_d  = shift_q;
                        received_valid_d = 1'b1;
                        state_d          = S_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (received_valid_q) begin
            if (nib[4]) begin
                acc_d = {acc_q[WW-5:0], nib[3:0]};
                if (count_q == MAX_DIGITS)
                    ovf_d = 1'b1;
                else
                    count_d = count_q + 1'b1;
            end else if (received_data_q == 8'd13 || received_data_q == 8'd10) begin
                if (count_q != '0) begin
                    word_d          = acc_q;
                    word_valid_d    = 1'b1;
                    word_overflow_d = ovf_q;
                end
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end else begin
                parse_error_d = 1'b1;
                acc_d         = '0;
                count_d       = '0;
                ovf_d         = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q        <= 1'b1;
            rx_s_q           <= 1'b1;
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            bit_idx_q        <= 3'd0;
            shift_q          <= 8'd0;
            received_data_q  <= 8'd0;
            received_valid_q <= 1'b0;
            framing_error_q  <= 1'b0;
            acc_q            <= '0;
            count_q          <= '0;
            ovf_q            <= 1'b0;
            word_q           <= '0;
            word_valid_q     <= 1'b0;
            word_overflow_q  <= 1'b0;
            parse_error_q    <= 1'b0;
        end else begin
            rx_meta_q        <= serial_in;
            rx_s_q           <= rx_meta_q;
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bit_idx_q        <= bit_idx_d;
            shift_q          <= shift_d;
            received_data_q  <= received_data_d;
            received_valid_q <= received_valid_d;
            framing_error_q  <= framing_error_d;
            acc_q            <= acc_d;
            count_q          <= count_d;
            ovf_q            <= ovf_d;
            word_q           <= word_d;
            word_valid_q     <= word_valid_d;
            word_overflow_q  <= word_overflow_d;
            parse_error_q    <= parse_error_d;
        end
    end

    assign received_data  = received_data_q;
    assign received_valid = received_valid_q;
    assign framing_error  = framing_error_q;
    assign word           = word_q;
    assign word_valid     = word_valid_q;
    assign word_overflow  = word_overflow_q;
    assign parse_error    = parse_error_q;

endmodule

// File: tb/tb_rs232in_hex.sv
// Directed bench for rs232in_hex at DIV=16: a line table plus hand-written
// sequences for exact timing, glitches, framing errors and mid-frame reset.
`timescale 1ns/1ps
module tb_rs232in_hex;
    localparam int FREQ = 64;
    localparam int BPS  = 4;
    localparam int DIV  = FREQ / BPS;
    localparam int WD   = 9;
    localparam int WW   = 4 * WD;
    // 2 sync flops + 1 detect edge + half bit + 8 data bits + stop bit
    localparam int RX_LATENCY = 3 + DIV / 2 + 9 * DIV;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic [7:0]    received_data;
    logic          received_valid;
    logic          framing_error;
    logic [WW-1:0] word;
    logic          word_valid;
    logic          word_overflow;
    logic          parse_error;

    rs232in_hex #(.frequency(FREQ), .bps(BPS), .word_digits(WD)) dut (
        .clock(clock),
        .reset(reset),
        .serial_in(serial_in),
        .received_data(received_data),
        .received_valid(received_valid),
        .framing_error(framing_error),
        .word(word),
        .word_valid(word_valid),
        .word_overflow(word_overflow),
        .parse_error(parse_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: collect every pulse on the falling edge.
    logic [7:0]  rx_got[$];
    int          rv_cyc[$];
    logic [WW:0] word_got[$];
    int          n_ferr = 0;
    int          n_perr = 0;
    int          lag_bad = 0;
    logic        prev_rv = 1'b0;

    always @(negedge clock) begin
        if (received_valid) begin
            rx_got.push_back(received_data);
            rv_cyc.push_back(cyc);
        end
        if (framing_error) n_ferr++;
        if (parse_error) n_perr++;
        if (word_valid) begin
            word_got.push_back({word_overflow, word});
            if (!prev_rv) lag_bad++;
        end
        prev_rv = received_valid;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_len, input logic stop_val);
        serial_in = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(DIV);
        end
        serial_in = stop_val;
        tick(stop_len);
        serial_in = 1'b1;
        tick(2 * DIV);
    endtask

    task automatic send_text(input logic [95:0] t, input int len);
        for (int i = 0; i < len; i++)
            send_byte(t[8*(len-1-i) +: 8], DIV, 1'b1);
    endtask

    typedef struct {
        logic [95:0]   text;
        int            len;
        int            exp_words;
        logic [WW-1:0] exp_word;
        logic          exp_ovf;
        int            exp_perr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        int base_rx, base_w, base_p, base_f, e;
        logic [7:0] exp_b;

        vecs[0] = '{"1aF\015\n",         5,  1, 36'h0000001AF, 1'b0, 0};
        vecs[1] = '{"123456789AB\015",   12, 1, 36'h3456789AB, 1'b1, 0};
        vecs[2] = '{"7\n",               2,  1, 36'h000000007, 1'b0, 0};
        vecs[3] = '{"12G3\015",          5,  1, 36'h000000003, 1'b0, 1};
        vecs[4] = '{"\015\n",            2,  0, 36'h000000000, 1'b0, 0};
        vecs[5] = '{"abcdef\n",          7,  1, 36'h000ABCDEF, 1'b0, 0};
        vecs[6] = '{"FFFFFFFFF\015",     10, 1, 36'hFFFFFFFFF, 1'b0, 0};
        vecs[7] = '{"FFFFFFFFF0\n",      11, 1, 36'hFFFFFFFF0, 1'b1, 0};
        vecs[8] = '{"0x5\015",           4,  1, 36'h000000005, 1'b0, 1};

        // Reset state
        tick(5);
        check("reset_outputs",
              {22'd0, received_data, received_valid, framing_error, word,
               word_valid, word_overflow, parse_error}, 64'd0);
        reset = 1'b0;
        tick(5);

        // Exact timing of a single byte, then terminate its digit
        base_rx = rx_got.size();
        base_w  = word_got.size();
        e = cyc;
        send_byte(8'h41, DIV, 1'b1);
        check("timing_count", 64'(rx_got.size() - base_rx), 64'd1);
        if (rx_got.size() > base_rx) begin
            check("timing_data", 64'(rx_got[base_rx]), 64'h41);
            check("timing_latency", 64'(rv_cyc[base_rx] - e), 64'(RX_LATENCY));
        end
        send_text("\015", 1);
        check("timing_word_count", 64'(word_got.size() - base_w), 64'd1);
        if (word_got.size() > base_w)
            check("timing_word", 64'(word_got[base_w]), 64'h00000000A);

        // Short low glitch on an idle line
        base_rx = rx_got.size();
        base_f  = n_ferr;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(40);
        check("glitch_no_valid", 64'(rx_got.size() - base_rx), 64'd0);
        check("glitch_no_ferr", 64'(n_ferr - base_f), 64'd0);
        check("glitch_idle", 64'(dut.state_q), 64'd0);

        // Line table
        for (int v = 0; v < NV; v++) begin
            base_rx = rx_got.size();
            base_w  = word_got.size();
            base_p  = n_perr;
            send_text(vecs[v].text, vecs[v].len);
            tick(10);
            check($sformatf("v%0d_rx_count", v), 64'(rx_got.size() - base_rx), 64'(vecs[v].len));
            for (int i = 0; i < vecs[v].len && base_rx + i < rx_got.size(); i++) begin
                exp_b = vecs[v].text[8*(vecs[v].len-1-i) +: 8];
                check($sformatf("v%0d_rx_byte%0d", v, i), 64'(rx_got[base_rx+i]), 64'(exp_b));
            end
            check($sformatf("v%0d_word_count", v), 64'(word_got.size() - base_w), 64'(vecs[v].exp_words));
            check($sformatf("v%0d_perr", v), 64'(n_perr - base_p), 64'(vecs[v].exp_perr));
            if (vecs[v].exp_words > 0 && word_got.size() > base_w) begin
                check($sformatf("v%0d_word", v), 64'(word_got[base_w][WW-1:0]), 64'(vecs[v].exp_word));
                check($sformatf("v%0d_ovf", v), 64'(word_got[base_w][WW]), 64'(vecs[v].exp_ovf));
            end
        end

        // Framing error between digits: bad byte dropped, partial word kept
        base_rx = rx_got.size();
        base_w  = word_got.size();
        base_f  = n_ferr;
        send_byte(8'h34, DIV, 1'b1);
        send_byte(8'h55, 40, 1'b0);
        send_byte(8'h31, DIV, 1'b1);
        send_text("\015", 1);
        check("frame_ferr_count", 64'(n_ferr - base_f), 64'd1);
        check("frame_rx_count", 64'(rx_got.size() - base_rx), 64'd3);
        if (rx_got.size() >= base_rx + 2)
            check("frame_after_byte", 64'(rx_got[base_rx+1]), 64'h31);
        check("frame_word_count", 64'(word_got.size() - base_w), 64'd1);
        if (word_got.size() > base_w)
            check("frame_word", 64'(word_got[base_w]), 64'h000000041);

        // Reset in the middle of a frame discards byte and partial word
        base_rx = rx_got.size();
        base_w  = word_got.size();
        base_f  = n_ferr;
        send_byte(8'h39, DIV, 1'b1);
        serial_in = 1'b0;
        tick(3 * DIV);
        reset = 1'b1;
        serial_in = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(20);
        send_text("5\015", 2);
        tick(10);
        check("rst_rx_count", 64'(rx_got.size() - base_rx), 64'd3);
        check("rst_ferr", 64'(n_ferr - base_f), 64'd0);
        check("rst_word_count", 64'(word_got.size() - base_w), 64'd1);
        if (word_got.size() > base_w)
            check("rst_word", 64'(word_got[base_w]), 64'h000000005);

        check("word_lag", 64'(lag_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
